tap_ctrl: RTL and testbench
===========================

TAP_CTRL -- requirements
Module: tap_ctrl

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 4, meaning instruction register length.
REQ-002 SHALL have parameter IDCODE, default 32'h1000_0001, meaning IDCODE capture value; bit 0 is always 1.
REQ-003 SHALL have port clk_in, input, 1, system clock; the block uses one clock only and samples TCK as data.
REQ-004 SHALL have port rst_in, input, 1, synchronous active-high reset.
REQ-005 SHALL have port pad_tap_tck, input, 1, JTAG TCK from the pad ring, asynchronous.
REQ-006 SHALL have port pad_tap_tms, input, 1, JTAG TMS from the pad ring, asynchronous.
REQ-007 SHALL have port pad_tap_tdi, input, 1, JTAG TDI from the pad ring, asynchronous.
REQ-008 SHALL have port tap_pad_tdo, output, 1, JTAG TDO to the pad ring.
REQ-009 SHALL have port tap_pad_tdo_oe, output, 1, TDO output enable.
REQ-010 SHALL have port tap_ir, output, IR_WIDTH, the active instruction.
REQ-011 SHALL have port tap_state, output, 4, the current TAP state encoding.

Function
REQ-012 SHALL pass TCK, TMS and TDI through 2-flop synchronizers in clk_in, then through one edge register; tck_rise = prev 0 and cur 1, tck_fall = prev 1 and cur 0.
REQ-013 SHALL see a pad TCK edge act 3 clk_in cycles later; each TCK high or low phase SHALL last at least 4 clk_in cycles.
REQ-014 SHALL implement the 16-state IEEE 1149.1 FSM: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
REQ-015 SHALL advance the FSM only on tck_rise, using the synchronized TMS.
REQ-016 SHALL reach TLR from any state after five consecutive tck_rise with TMS=1.
REQ-017 SHALL, on tck_rise in CapIR, load the IR shift register with 'b0001 (zero-extended to IR_WIDTH).
REQ-018 SHALL, on tck_rise in ShIR, shift the IR shift register right with TDI entering at the MSB.
REQ-019 SHALL, on tck_rise in UpdIR, copy the IR shift register to tap_ir.
REQ-020 SHALL decode instructions as: 'b0001 = IDCODE (32-bit DR), all ones = BYPASS (1-bit DR), any other code = BYPASS.
REQ-021 SHALL, on tck_rise in CapDR, load the selected DR: IDCODE for IDCODE, 0 for BYPASS.
REQ-022 SHALL, on tck_rise in ShDR, shift the selected DR right with TDI entering at the MSB.
REQ-023 SHALL, on tck_fall in ShIR or ShDR, set tap_pad_tdo to the LSB of the active shift register and set tap_pad_tdo_oe=1.
REQ-024 SHALL, on tck_fall in any other state, set tap_pad_tdo=0 and tap_pad_tdo_oe=0.
REQ-025 SHALL, while in TLR, force tap_ir to IDCODE.
REQ-026 SHALL treat simultaneous tck_rise and tck_fall as impossible; no tie-break logic is required.

Reset
REQ-027 SHALL, on rst_in=1 at a clk_in edge, set FSM=TLR, tap_ir=IDCODE, all shift registers=0, tap_pad_tdo=0, tap_pad_tdo_oe=0, synchronizers and edge register=0.
REQ-028 SHALL, on reset mid-shift, abort the shift with no update; the first tck_rise after reset is evaluated from TLR.

Configuration
REQ-029 SHALL, with TAP_USER_DR_EN defined, add instruction 'b1000 = USER with a 32-bit DR, plus ports user_dr_capture_data (input, 32), user_dr_update_data (output, 32, reset 0) and user_dr_update_valid (output, 1, reset 0).
REQ-030 SHALL, with TAP_USER_DR_EN defined, load user_dr_capture_data in CapDR, and in UpdDR register the shift value onto user_dr_update_data and pulse user_dr_update_valid for exactly 1 clk_in cycle.
REQ-031 SHALL, without TAP_USER_DR_EN, omit those ports and decode 'b1000 as BYPASS.

Structure
REQ-032 SHALL place the TAP state encodings and instruction opcodes (IDCODE, BYPASS, USER) in a shared package/include alongside nanorv32_parameters.v.
REQ-033 SHALL implement the synchronizer-plus-edge-detector as one sub-module, tap_sync_edge, instantiated once per pad input.

Verification
REQ-034 SHALL cover: rst_in pulse, then TMS=1 for 5 TCK -> tap_state=TLR, tap_ir='b0001, tdo_oe=0.
REQ-035 SHALL cover: from RTI, Shift-DR 32 bits under IDCODE -> TDO emits 32'h1000_0001 LSB first, oe=1 only during ShDR.
REQ-036 SHALL cover: Shift-IR 'b1111, UpdIR, then shift 8 bits TDI=8'hA5 -> TDO = 0 followed by 8'hA5 delayed one TCK.
REQ-037 SHALL cover: Shift-IR with 'b1010 in -> TDO emits 'b0001 during the shift; tap_ir=1010 after UpdIR; DR behaves as BYPASS.
REQ-038 SHALL cover: rst_in asserted mid-ShDR -> next clk_in FSM=TLR, oe=0, tap_ir unchanged from IDCODE.
REQ-039 SHALL cover, with TAP_USER_DR_EN: capture 32'hDEAD_BEEF, shift in 32'h1234_5678 -> TDO emits DEADBEEF; after UpdDR, update_data=32'h1234_5678 with a 1-cycle valid.

Source files
------------

// File: rtl/tap_ctrl_pkg.sv
// Shared TAP definitions: state encodings, instruction opcodes, DR selection
// and the IEEE 1149.1 next-state function.
package tap_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_EX2_DR   = 4'h0,
    ST_EX1_DR   = 4'h1,
    ST_SH_DR    = 4'h2,
    ST_PAUSE_DR = 4'h3,
    ST_SEL_IR   = 4'h4,
    ST_UPD_DR   = 4'h5,
    ST_CAP_DR   = 4'h6,
    ST_SEL_DR   = 4'h7,
    ST_EX2_IR   = 4'h8,
    ST_EX1_IR   = 4'h9,
    ST_SH_IR    = 4'hA,
    ST_PAUSE_IR = 4'hB,
    ST_RTI      = 4'hC,
    ST_UPD_IR   = 4'hD,
    ST_CAP_IR   = 4'hE,
    ST_TLR      = 4'hF
  } tap_state_e;

  localparam logic [3:0] OPC_IDCODE = 4'b0001;
  localparam logic [3:0] OPC_USER   = 4'b1000;
  localparam logic [3:0] OPC_BYPASS = 4'b1111;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2
  } dr_sel_e;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      ST_TLR:      tap_next = tms ? ST_TLR      : ST_RTI;
      ST_RTI:      tap_next = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   tap_next = tms ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   tap_next = tms ? ST_EX1_DR   : ST_SH_DR;
      ST_SH_DR:    tap_next = tms ? ST_EX1_DR   : ST_SH_DR;
      ST_EX1_DR:   tap_next = tms ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: tap_next = tms ? ST_EX2_DR   : ST_PAUSE_DR;
      ST_EX2_DR:   tap_next = tms ? ST_UPD_DR   : ST_SH_DR;
      ST_UPD_DR:   tap_next = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   tap_next = tms ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   tap_next = tms ? ST_EX1_IR   : ST_SH_IR;
      ST_SH_IR:    tap_next = tms ? ST_EX1_IR   : ST_SH_IR;
      ST_EX1_IR:   tap_next = tms ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: tap_next = tms ? ST_EX2_IR   : ST_PAUSE_IR;
      ST_EX2_IR:   tap_next = tms ? ST_UPD_IR   : ST_SH_IR;
      ST_UPD_IR:   tap_next = tms ? ST_SEL_DR   : ST_RTI;
      default:     tap_next = ST_TLR;
    endcase
  endfunction

endpackage

// File: rtl/tap_sync_edge.sv
// Two-flop synchronizer for one asynchronous pad input followed by an edge
// register; rise/fall are single clk cycle pulses.
module tap_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // synchronizer chain plus previous-value register
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= pad;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign level = sync_r;
  assign rise  = sync_r & ~prev_r;
  assign fall  = ~sync_r & prev_r;

endmodule

// File: rtl/tap_ctrl.sv
// JTAG TAP controller oversampling TCK in the clk_in domain.
// Optional USER data register enabled by defining TAP_USER_DR_EN.
module tap_ctrl
  import tap_ctrl_pkg::*;
#(
  parameter int          IR_WIDTH = 4,
  parameter logic [31:0] IDCODE   = 32'h1000_0001
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                pad_tap_tck,
  input  logic                pad_tap_tms,
  input  logic                pad_tap_tdi,
  output logic                tap_pad_tdo,
  output logic                tap_pad_tdo_oe,
  output logic [IR_WIDTH-1:0] tap_ir,
  output logic [3:0]          tap_state
`ifdef TAP_USER_DR_EN
  ,
  input  logic [31:0]         user_dr_capture_data,
  output logic [31:0]         user_dr_update_data,
  output logic                user_dr_update_valid
`endif
);

  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(OPC_IDCODE);
`ifdef TAP_USER_DR_EN
  localparam logic [IR_WIDTH-1:0] IR_USER   = IR_WIDTH'(OPC_USER);
`endif

  logic tck_level_s, tck_rise_s, tck_fall_s;
  logic tms_s, tms_rise_s, tms_fall_s;
  logic tdi_s, tdi_rise_s, tdi_fall_s;
  logic unused_edges_s;

  tap_state_e            state_r;
  tap_state_e            next_state_s;
  dr_sel_e               dr_sel_s;
  logic [IR_WIDTH-1:0]   ir_shift_r;
  logic [31:0]           dr_shift_r;
  logic                  bypass_r;

  tap_sync_edge u_sync_tck (
    .clk(clk_in), .rst(rst_in), .pad(pad_tap_tck),
    .level(tck_level_s), .rise(tck_rise_s), .fall(tck_fall_s)
  );

  tap_sync_edge u_sync_tms (
    .clk(clk_in), .rst(rst_in), .pad(pad_tap_tms),
    .level(tms_s), .rise(tms_rise_s), .fall(tms_fall_s)
  );

  tap_sync_edge u_sync_tdi (
    .clk(clk_in), .rst(rst_in), .pad(pad_tap_tdi),
    .level(tdi_s), .rise(tdi_rise_s), .fall(tdi_fall_s)
  );

  assign unused_edges_s = ^{tck_level_s, tms_rise_s, tms_fall_s, tdi_rise_s, tdi_fall_s};

  // TAP state register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= ST_TLR;
    end else begin
      state_r <= next_state_s;
    end
  end

  // next state: the FSM only moves on a synchronized TCK rising edge
  always_comb begin
    next_state_s = state_r;
    if (tck_rise_s) begin
      next_state_s = tap_next(state_r, tms_s);
    end else begin
      next_state_s = state_r;
    end
  end

  // instruction decode; unknown opcodes fall back to BYPASS
  always_comb begin
    dr_sel_s = DR_BYPASS;
    if (tap_ir == IR_IDCODE) begin
      dr_sel_s = DR_IDCODE;
    end
`ifdef TAP_USER_DR_EN
    else if (tap_ir == IR_USER) begin
      dr_sel_s = DR_USER;
    end
`endif
    else begin
      dr_sel_s = DR_BYPASS;
    end
  end

  assign tap_state = state_r;

  // shift registers, instruction register and TDO, all paced by TCK edges
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ir_shift_r     <= '0;
      dr_shift_r     <= 32'h0000_0000;
      bypass_r       <= 1'b0;
      tap_ir         <= IR_IDCODE;
      tap_pad_tdo    <= 1'b0;
      tap_pad_tdo_oe <= 1'b0;
`ifdef TAP_USER_DR_EN
      user_dr_update_data  <= 32'h0000_0000;
      user_dr_update_valid <= 1'b0;
`endif
    end else begin
`ifdef TAP_USER_DR_EN
      user_dr_update_valid <= 1'b0;
`endif
      if (tck_rise_s) begin
        case (state_r)
          ST_CAP_IR: ir_shift_r <= IR_IDCODE;
          ST_SH_IR:  ir_shift_r <= {tdi_s, ir_shift_r[IR_WIDTH-1:1]};
          ST_UPD_IR: tap_ir     <= ir_shift_r;
          ST_CAP_DR: begin
            case (dr_sel_s)
              DR_IDCODE: dr_shift_r <= IDCODE;
`ifdef TAP_USER_DR_EN
              DR_USER:   dr_shift_r <= user_dr_capture_data;
`endif
              default:   bypass_r   <= 1'b0;
            endcase
          end
          ST_SH_DR: begin
            case (dr_sel_s)
              DR_IDCODE, DR_USER: dr_shift_r <= {tdi_s, dr_shift_r[31:1]};
              default:            bypass_r   <= tdi_s;
            endcase
          end
`ifdef TAP_USER_DR_EN
          ST_UPD_DR: begin
            if (dr_sel_s == DR_USER) begin
              user_dr_update_data  <= dr_shift_r;
              user_dr_update_valid <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
        // Test-Logic-Reset always presents IDCODE as the active instruction
        if (next_state_s == ST_TLR) begin
          tap_ir <= IR_IDCODE;
        end
      end
      if (tck_fall_s) begin
        if (state_r == ST_SH_IR) begin
          tap_pad_tdo    <= ir_shift_r[0];
          tap_pad_tdo_oe <= 1'b1;
        end else if (state_r == ST_SH_DR) begin
          tap_pad_tdo    <= (dr_sel_s == DR_BYPASS) ? bypass_r : dr_shift_r[0];
          tap_pad_tdo_oe <= 1'b1;
        end else begin
          tap_pad_tdo    <= 1'b0;
          tap_pad_tdo_oe <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tap_ctrl.sv
// Directed bench for tap_ctrl: table-driven FSM walk plus hand-written
// IDCODE, BYPASS, unknown-opcode, mid-shift reset and optional USER sequences.
module tb_tap_ctrl;
  import tap_ctrl_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       tck = 1'b0;
  logic       tms = 1'b0;
  logic       tdi = 1'b0;
  logic       tdo, tdo_oe;
  logic [3:0] ir;
  logic [3:0] st;
`ifdef TAP_USER_DR_EN
  logic [31:0] cap_data = 32'h0000_0000;
  logic [31:0] upd_data;
  logic        upd_valid;
  int          vcnt = 0;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  tap_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .pad_tap_tck(tck), .pad_tap_tms(tms), .pad_tap_tdi(tdi),
    .tap_pad_tdo(tdo), .tap_pad_tdo_oe(tdo_oe),
    .tap_ir(ir), .tap_state(st)
`ifdef TAP_USER_DR_EN
    ,
    .user_dr_capture_data(cap_data),
    .user_dr_update_data(upd_data),
    .user_dr_update_valid(upd_valid)
`endif
  );

  always #5 clk_in = ~clk_in;

`ifdef TAP_USER_DR_EN
  always @(posedge clk_in) if (upd_valid) vcnt <= vcnt + 1;
`endif

  typedef struct {
    logic       tms;
    logic       tdi;
    logic [3:0] st;
    logic       tdo;
    logic       oe;
    logic [3:0] ir;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // one full TCK period; 5 clk_in cycles per phase so both edges have acted
  task automatic tck_pulse(input logic m, input logic d);
    tms = m;
    tdi = d;
    repeat (5) @(negedge clk_in);
    tck = 1'b1;
    repeat (5) @(negedge clk_in);
    tck = 1'b0;
    repeat (5) @(negedge clk_in);
  endtask

  task automatic tms_walk(input logic [7:0] bits, input int n);
    for (int i = 0; i < n; i++) tck_pulse(bits[i], 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  // from RTI: load an instruction, checking captured 0001 on TDO, end in RTI
  task automatic shift_ir(input logic [3:0] val);
    logic [3:0] cap;
    cap = 4'b0001;
    tms_walk(8'b0000_0011, 4);
    chk("ir_enter_shift", {28'd0, st}, {28'd0, ST_SH_IR});
    for (int i = 0; i < 4; i++) begin
      chk("ir_tdo", {31'd0, tdo}, {31'd0, cap[i]});
      chk("ir_oe", {31'd0, tdo_oe}, 32'd1);
      tck_pulse(i == 3, val[i]);
    end
    chk("ir_exit_oe", {31'd0, tdo_oe}, 32'd0);
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    chk("ir_update", {28'd0, ir}, {28'd0, val});
  endtask

  initial begin
    logic [8:0]  bp;
    logic [31:0] idc;
    tbl = '{
      '{1'b0, 1'b0, ST_RTI,      1'b0, 1'b0, 4'b0001},
      '{1'b1, 1'b0, ST_SEL_DR,   1'b0, 1'b0, 4'b0001},
      '{1'b0, 1'b0, ST_CAP_DR,   1'b0, 1'b0, 4'b0001},
      '{1'b1, 1'b0, ST_EX1_DR,   1'b0, 1'b0, 4'b0001},
      '{1'b0, 1'b0, ST_PAUSE_DR, 1'b0, 1'b0, 4'b0001},
      '{1'b1, 1'b0, ST_EX2_DR,   1'b0, 1'b0, 4'b0001},
      '{1'b0, 1'b0, ST_SH_DR,    1'b1, 1'b1, 4'b0001},
      '{1'b1, 1'b0, ST_EX1_DR,   1'b0, 1'b0, 4'b0001},
      '{1'b1, 1'b0, ST_UPD_DR,   1'b0, 1'b0, 4'b0001},
      '{1'b1, 1'b0, ST_SEL_DR,   1'b0, 1'b0, 4'b0001},
      '{1'b1, 1'b0, ST_SEL_IR,   1'b0, 1'b0, 4'b0001},
      '{1'b0, 1'b0, ST_CAP_IR,   1'b0, 1'b0, 4'b0001},
      '{1'b1, 1'b0, ST_EX1_IR,   1'b0, 1'b0, 4'b0001},
      '{1'b0, 1'b0, ST_PAUSE_IR, 1'b0, 1'b0, 4'b0001},
      '{1'b1, 1'b0, ST_EX2_IR,   1'b0, 1'b0, 4'b0001},
      '{1'b0, 1'b0, ST_SH_IR,    1'b1, 1'b1, 4'b0001},
      '{1'b1, 1'b0, ST_EX1_IR,   1'b0, 1'b0, 4'b0001},
      '{1'b1, 1'b0, ST_UPD_IR,   1'b0, 1'b0, 4'b0001},
      '{1'b0, 1'b0, ST_RTI,      1'b0, 1'b0, 4'b0000},
      '{1'b1, 1'b0, ST_SEL_DR,   1'b0, 1'b0, 4'b0000},
      '{1'b1, 1'b0, ST_SEL_IR,   1'b0, 1'b0, 4'b0000},
      '{1'b1, 1'b0, ST_TLR,      1'b0, 1'b0, 4'b0001},
      '{1'b1, 1'b0, ST_TLR,      1'b0, 1'b0, 4'b0001}
    };

    do_reset();
    chk("reset_state", {28'd0, st}, {28'd0, ST_TLR});
    chk("reset_ir", {28'd0, ir}, 32'd1);
    chk("reset_tdo", {31'd0, tdo}, 32'd0);
    chk("reset_oe", {31'd0, tdo_oe}, 32'd0);

    for (int i = 0; i < 23; i++) begin
      tck_pulse(tbl[i].tms, tbl[i].tdi);
      chk($sformatf("walk%0d_state", i), {28'd0, st}, {28'd0, tbl[i].st});
      chk($sformatf("walk%0d_tdo", i), {31'd0, tdo}, {31'd0, tbl[i].tdo});
      chk($sformatf("walk%0d_oe", i), {31'd0, tdo_oe}, {31'd0, tbl[i].oe});
      chk($sformatf("walk%0d_ir", i), {28'd0, ir}, {28'd0, tbl[i].ir});
    end

    // five TMS=1 from Shift-IR lands in TLR
    tms_walk(8'b0000_0110, 5);
    chk("to_shir", {28'd0, st}, {28'd0, ST_SH_IR});
    tms_walk(8'h1F, 5);
    chk("tlr5_state", {28'd0, st}, {28'd0, ST_TLR});
    chk("tlr5_oe", {31'd0, tdo_oe}, 32'd0);

    do_reset();
    tms_walk(8'h1F, 5);
    chk("rst_tlr_state", {28'd0, st}, {28'd0, ST_TLR});
    chk("rst_tlr_ir", {28'd0, ir}, 32'd1);
    chk("rst_tlr_oe", {31'd0, tdo_oe}, 32'd0);

    // IDCODE shift, LSB first
    idc = 32'h1000_0001;
    tms_walk(8'b0000_0010, 4);
    chk("idc_shdr", {28'd0, st}, {28'd0, ST_SH_DR});
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("idc_tdo%0d", i), {31'd0, tdo}, {31'd0, idc[i]});
      chk("idc_oe", {31'd0, tdo_oe}, 32'd1);
      tck_pulse(i == 31, 1'b0);
    end
    chk("idc_exit_state", {28'd0, st}, {28'd0, ST_EX1_DR});
    chk("idc_exit_oe", {31'd0, tdo_oe}, 32'd0);
    tms_walk(8'b0000_0001, 2);
    chk("idc_rti", {28'd0, st}, {28'd0, ST_RTI});

    // explicit BYPASS: TDO is TDI delayed one TCK after a leading 0
    shift_ir(4'b1111);
    bp = {1'b0, 8'hA5};
    tms_walk(8'b0000_0001, 3);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("byp_tdo%0d", k), {31'd0, tdo}, (k == 0) ? 32'd0 : {31'd0, bp[k-1]});
      tck_pulse(k == 8, bp[k]);
    end
    tms_walk(8'b0000_0001, 2);

    // unknown opcode behaves as BYPASS
    shift_ir(4'b1010);
    tms_walk(8'b0000_0001, 3);
    chk("unk_tdo0", {31'd0, tdo}, 32'd0);
    tck_pulse(1'b0, 1'b1);
    chk("unk_tdo1", {31'd0, tdo}, 32'd1);
    tck_pulse(1'b0, 1'b0);
    chk("unk_tdo2", {31'd0, tdo}, 32'd0);
    tck_pulse(1'b1, 1'b0);
    chk("unk_exit_oe", {31'd0, tdo_oe}, 32'd0);
    tms_walk(8'b0000_0001, 2);

    // reset in the middle of a DR shift
    tms_walk(8'h1F, 5);
    tms_walk(8'b0000_0010, 4);
    tms_walk(8'b0000_0000, 3);
    chk("mid_oe_before", {31'd0, tdo_oe}, 32'd1);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("mid_rst_state", {28'd0, st}, {28'd0, ST_TLR});
    chk("mid_rst_oe", {31'd0, tdo_oe}, 32'd0);
    chk("mid_rst_ir", {28'd0, ir}, 32'd1);
    rst_in = 1'b0;
    tck_pulse(1'b0, 1'b0);
    chk("mid_after_rti", {28'd0, st}, {28'd0, ST_RTI});

`ifdef TAP_USER_DR_EN
    begin
      logic [31:0] din;
      logic [31:0] capv;
      int          v0;
      capv = 32'hDEAD_BEEF;
      din  = 32'h1234_5678;
      cap_data = capv;
      shift_ir(4'b1000);
      tms_walk(8'b0000_0001, 3);
      for (int i = 0; i < 32; i++) begin
        chk($sformatf("usr_tdo%0d", i), {31'd0, tdo}, {31'd0, capv[i]});
        tck_pulse(i == 31, din[i]);
      end
      tck_pulse(1'b1, 1'b0);
      v0 = vcnt;
      tck_pulse(1'b0, 1'b0);
      chk("usr_upd_data", upd_data, din);
      chk("usr_valid_cycles", vcnt - v0, 32'd1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
